uart_rx: RTL

- 16x-oversampling UART receiver. It sits directly downstream of the baud generator and consumes its os_tick strobe.
- It deserialises 8N1 frames from the rx pin, LSB first.
- It presents each byte on a one-entry valid/ready output register to the command decoder of the GPU front end.
- It flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default parameters for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int OS_DEFAULT        = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    function automatic int half_bit(input int os);
        return os / 2 - 1;
    endfunction

    localparam int HALF_BIT = half_bit(OS_DEFAULT);

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input pin
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // two back-to-back flops; reset to the pin's idle level
    always_ff @(posedge CLK) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with one-entry valid/ready output; even parity when UART_RX_PARITY_EN is defined
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int OS        = OS_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int OS_W = $clog2(OS);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] HALF      = OS_W'(half_bit(OS));
    localparam logic [OS_W-1:0] LAST      = OS_W'(OS - 1);
    localparam logic [BC_W-1:0] BITS_LAST = BC_W'(DATA_BITS - 1);

    state_t               state, state_n;
    logic [OS_W-1:0]      os_cnt, os_cnt_n;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 armed, armed_n;
    logic                 rx_s, done, ferr;
`ifdef UART_RX_PARITY_EN
    logic                 par, par_n, perr;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .CLK (CLK),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign busy = state != IDLE;

    // receiver state and counters
    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            armed   <= armed_n;
`ifdef UART_RX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    // next-state: armed only after seeing idle-high, so a held-low break cannot retrigger
    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        armed_n   = armed;
        done      = 1'b0;
        ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n     = par;
        perr      = 1'b0;
`endif
        if (os_tick && state != IDLE) os_cnt_n = os_cnt + 1'b1;
        case (state)
            IDLE: begin
                armed_n = armed | rx_s;
                if (armed && !rx_s) begin
                    state_n  = START;
                    os_cnt_n = '0;
                end
            end
            START: if (os_tick && os_cnt == HALF) begin
                state_n   = rx_s ? IDLE : DATA;
                os_cnt_n  = '0;
                bit_cnt_n = '0;
            end
            DATA: if (os_tick && os_cnt == LAST) begin
                shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                bit_cnt_n = bit_cnt + 1'b1;
                os_cnt_n  = '0;
`ifdef UART_RX_PARITY_EN
                if (bit_cnt == BITS_LAST) state_n = PARITY;
`else
                if (bit_cnt == BITS_LAST) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (os_tick && os_cnt == LAST) begin
                par_n    = rx_s;
                os_cnt_n = '0;
                state_n  = STOP;
            end
`endif
            STOP: if (os_tick && os_cnt == LAST) begin
                state_n  = IDLE;
                armed_n  = 1'b0;
                os_cnt_n = '0;
                ferr     = !rx_s;
`ifdef UART_RX_PARITY_EN
                perr     = ^{shreg, par};
                done     = rx_s && !perr;
`else
                done     = rx_s;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // one-entry output buffer and error pulses
    always_ff @(posedge CLK) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= ferr;
            overrun    <= done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr;
`endif
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
